// File: rtl/redmule_mesh_l2_burst_mgr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | redmule_mesh_l2_burst_mgr: single-outstanding AXI4 INCR burst manager     |
// | Optional stats outputs with `define REDMULE_MESH_L2_MGR_STATS_EN         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

package redmule_mesh_l2_burst_mgr_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [5:0]  atop;
    logic [0:0]  user;
  } axi_l2_vip_aw_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [0:0]  user;
  } axi_l2_vip_ar_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
    logic [0:0]  user;
  } axi_l2_vip_w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
    logic [0:0] user;
  } axi_l2_vip_b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [0:0]  user;
  } axi_l2_vip_r_chan_t;

  typedef struct packed {
    axi_l2_vip_aw_chan_t aw;
    logic                aw_valid;
    axi_l2_vip_w_chan_t  w;
    logic                w_valid;
    logic                b_ready;
    axi_l2_vip_ar_chan_t ar;
    logic                ar_valid;
    logic                r_ready;
  } axi_l2_vip_req_t;

  typedef struct packed {
    logic               aw_ready;
    logic               ar_ready;
    logic               w_ready;
    logic               b_valid;
    axi_l2_vip_b_chan_t b;
    logic               r_valid;
    axi_l2_vip_r_chan_t r;
  } axi_l2_vip_rsp_t;
endpackage

module redmule_mesh_l2_burst_mgr
  import redmule_mesh_l2_burst_mgr_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned AXI_ID    = 0,
  parameter type         axi_req_t = axi_l2_vip_req_t,
  parameter type         axi_rsp_t = axi_l2_vip_rsp_t
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [ADDR_W-1:0]   cmd_addr_i,
  input  logic [7:0]          cmd_len_i,
  input  logic                wdata_valid_i,
  output logic                wdata_ready_o,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  output logic                rdata_valid_o,
  input  logic                rdata_ready_i,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                rdata_last_o,
  output logic                done_o,
  output logic                err_o,
  output logic                busy_o,
  output axi_req_t            axi_req_o,
  input  axi_rsp_t            axi_rsp_i
`ifdef REDMULE_MESH_L2_MGR_STATS_EN
  ,
  output logic [15:0]         stats_wr_o,
  output logic [15:0]         stats_rd_o,
  output logic [15:0]         stats_err_o
`endif
);

  localparam int unsigned STRB_W   = DATA_W / 8;
  localparam int unsigned OFF_W    = $clog2(STRB_W);
  localparam logic [31:0] AXI_ID_L = AXI_ID;

  typedef enum logic [2:0] {
    S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic              ill_q, ill_d;

  // Burst end is formed one bit wider so a wrap past the top of memory still flags a crossing.
  logic [ADDR_W:0] span;
  logic [ADDR_W:0] burst_end;
  logic            cmd_illegal;

  assign span        = (ADDR_W+1)'(cmd_len_i) + (ADDR_W+1)'(1);
  assign burst_end   = {1'b0, cmd_addr_i} + (span << OFF_W) - (ADDR_W+1)'(1);
  assign cmd_illegal = (cmd_addr_i[OFF_W-1:0] != '0) ||
                       (burst_end[ADDR_W:12] != {1'b0, cmd_addr_i[ADDR_W-1:12]});

  logic unused_bits;
  assign unused_bits = ^{axi_rsp_i, burst_end[11:0]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      we_q    <= we_d;
      ill_q   <= ill_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    we_d          = we_q;
    ill_d         = ill_q;
    cmd_ready_o   = 1'b0;
    wdata_ready_o = 1'b0;
    rdata_valid_o = 1'b0;
    rdata_o       = axi_rsp_i.r.data;
    rdata_last_o  = axi_rsp_i.r.last;

    axi_req_o          = '0;
    axi_req_o.aw.id    = AXI_ID_L[$bits(axi_req_o.aw.id)-1:0];
    axi_req_o.aw.addr  = addr_q;
    axi_req_o.aw.len   = len_q;
    axi_req_o.aw.size  = 3'(OFF_W);
    axi_req_o.aw.burst = 2'b01;
    axi_req_o.ar.id    = AXI_ID_L[$bits(axi_req_o.ar.id)-1:0];
    axi_req_o.ar.addr  = addr_q;
    axi_req_o.ar.len   = len_q;
    axi_req_o.ar.size  = 3'(OFF_W);
    axi_req_o.ar.burst = 2'b01;
    axi_req_o.w.data   = wdata_i;
    axi_req_o.w.strb   = wstrb_i;
    axi_req_o.w.last   = (cnt_q == len_q);

    unique case (state_q)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          addr_d  = cmd_addr_i;
          len_d   = cmd_len_i;
          we_d    = cmd_we_i;
          cnt_d   = '0;
          err_d   = cmd_illegal;
          ill_d   = cmd_illegal;
          state_d = cmd_illegal ? S_DONE : (cmd_we_i ? S_AW : S_AR);
        end
      end
      S_AW: begin
        axi_req_o.aw_valid = 1'b1;
        if (axi_rsp_i.aw_ready) state_d = S_W;
      end
      S_W: begin
        axi_req_o.w_valid = wdata_valid_i;
        wdata_ready_o     = axi_rsp_i.w_ready;
        if (wdata_valid_i && axi_rsp_i.w_ready) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == len_q) state_d = S_B;
        end
      end
      S_B: begin
        axi_req_o.b_ready = 1'b1;
        if (axi_rsp_i.b_valid) begin
          if (axi_rsp_i.b.resp != 2'b00) err_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_AR: begin
        axi_req_o.ar_valid = 1'b1;
        if (axi_rsp_i.ar_ready) state_d = S_R;
      end
      S_R: begin
        axi_req_o.r_ready = rdata_ready_i;
        rdata_valid_o     = axi_rsp_i.r_valid;
        if (axi_rsp_i.r_valid && rdata_ready_i) begin
          cnt_d = cnt_q + 8'd1;
          if (axi_rsp_i.r.resp != 2'b00) err_d = 1'b1;
          // A misplaced or missing RLAST is an error; beat len always closes the burst.
          if (axi_rsp_i.r.last != (cnt_q == len_q)) err_d = 1'b1;
          if (axi_rsp_i.r.last || (cnt_q == len_q)) state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign done_o = (state_q == S_DONE);
  assign err_o  = err_q;
  assign busy_o = (state_q != S_IDLE);

`ifdef REDMULE_MESH_L2_MGR_STATS_EN
  logic [15:0] stats_wr_q, stats_rd_q, stats_err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stats_wr_q  <= '0;
      stats_rd_q  <= '0;
      stats_err_q <= '0;
    end else if (state_q == S_DONE) begin
      if (!ill_q && we_q && (stats_wr_q != 16'hFFFF))   stats_wr_q  <= stats_wr_q + 16'd1;
      if (!ill_q && !we_q && (stats_rd_q != 16'hFFFF))  stats_rd_q  <= stats_rd_q + 16'd1;
      if (err_q && (stats_err_q != 16'hFFFF))           stats_err_q <= stats_err_q + 16'd1;
    end
  end

  assign stats_wr_o  = stats_wr_q;
  assign stats_rd_o  = stats_rd_q;
  assign stats_err_o = stats_err_q;
`endif

endmodule
`default_nettype wire
